// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with private HI/LO registers for the EX stage.
// Optional MDU_FLUSH_EN adds a Flush input that aborts in-flight operations and suppresses launches.
module mult_div_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
`ifdef MDU_FLUSH_EN
  input  logic        Flush,
`endif
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  MDOp,
  input  logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDOut
);

  localparam int unsigned MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int          CLOG = $clog2(MAXC + 1);
  localparam int          CW   = (CLOG > 4) ? CLOG : 4;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          busy_n;
  logic [31:0]   hi_n, lo_n;
  logic [31:0]   phi, plo, phi_n, plo_n;
  logic          skip, skip_n;
  logic          flush;

`ifdef MDU_FLUSH_EN
  assign flush = Flush;
`else
  assign flush = 1'b0;
`endif

  // Multiply datapath
  logic signed [63:0] sa64, sb64;
  logic [63:0]        prod_s, prod_u;

  assign sa64   = {{32{A[31]}}, A};
  assign sb64   = {{32{B[31]}}, B};
  assign prod_s = sa64 * sb64;
  assign prod_u = {32'b0, A} * {32'b0, B};

  // Shared unsigned divider; signed division works on magnitudes and fixes signs afterwards
  logic        sgn_div, a_neg, b_neg;
  logic [31:0] a_mag, b_mag, dvd, dvs, quo_u, rem_u, quo, rem;

  assign sgn_div = (MDOp == 4'd2);
  assign a_neg   = sgn_div & A[31];
  assign b_neg   = sgn_div & B[31];
  assign a_mag   = a_neg ? (32'd0 - A) : A;
  assign b_mag   = b_neg ? (32'd0 - B) : B;
  assign dvd     = a_mag;
  assign dvs     = b_mag;
  assign quo_u   = (dvs == '0) ? '0 : (dvd / dvs);
  assign rem_u   = (dvs == '0) ? '0 : (dvd % dvs);
  assign quo     = (a_neg ^ b_neg) ? (32'd0 - quo_u) : quo_u;
  assign rem     = a_neg ? (32'd0 - rem_u) : rem_u;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    hi_n    = HI;
    lo_n    = LO;
    phi_n   = phi;
    plo_n   = plo;
    skip_n  = skip;
    unique case (state)
      IDLE: begin
        if (Start && !flush) begin
          case (MDOp)
            4'd0: begin
              phi_n   = prod_s[63:32];
              plo_n   = prod_s[31:0];
              skip_n  = 1'b0;
              cnt_n   = CW'(MULT_CYCLES);
              state_n = RUN;
            end
            4'd1: begin
              phi_n   = prod_u[63:32];
              plo_n   = prod_u[31:0];
              skip_n  = 1'b0;
              cnt_n   = CW'(MULT_CYCLES);
              state_n = RUN;
            end
            4'd2, 4'd3: begin
              // Divide by zero still occupies the full latency but commits nothing
              if (B == '0) begin
                skip_n = 1'b1;
              end else begin
                skip_n = 1'b0;
                phi_n  = rem;
                plo_n  = quo;
              end
              cnt_n   = CW'(DIV_CYCLES);
              state_n = RUN;
            end
            4'd6:    hi_n = A;
            4'd7:    lo_n = A;
            default: ;
          endcase
        end
      end
      RUN: begin
        if (flush) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == CW'(1)) begin
          if (!skip) begin
            hi_n = phi;
            lo_n = plo;
          end
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n == RUN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      Busy  <= 1'b0;
      HI    <= '0;
      LO    <= '0;
      phi   <= '0;
      plo   <= '0;
      skip  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      Busy  <= busy_n;
      HI    <= hi_n;
      LO    <= lo_n;
      phi   <= phi_n;
      plo   <= plo_n;
      skip  <= skip_n;
    end
  end

  always_comb begin
    MDOut = '0;
    if (MDOp == 4'd4)      MDOut = HI;
    else if (MDOp == 4'd5) MDOut = LO;
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases with literal expectations plus
// randomized traffic compared every cycle against an arithmetic reference model.
module tb_mult_div_unit;

  localparam int unsigned MC = 5;
  localparam int unsigned DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] a_in, b_in;
  logic [3:0]  md_op;
  logic        start;
  logic        busy;
  logic [31:0] hi, lo, md_out;

  int checks = 0;
  int errors = 0;

  mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .A     (a_in),
    .B     (b_in),
    .MDOp  (md_op),
    .Start (start),
    .Busy  (busy),
    .HI    (hi),
    .LO    (lo),
    .MDOut (md_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: returns {valid, hi, lo}; valid=0 means nothing to commit
  function automatic logic [64:0] compute(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, q, r, ps;
    longint unsigned ua, ub, pu, qu, ru;
    logic [63:0]     res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    res = '0;
    case (op)
      4'd0: begin ps = sa * sb; res = ps; end
      4'd1: begin pu = ua * ub; res = pu; end
      4'd2: begin
        if (b == 32'd0) return {1'b0, 64'd0};
        q = sa / sb; r = sa % sb;
        res = {r[31:0], q[31:0]};
      end
      4'd3: begin
        if (b == 32'd0) return {1'b0, 64'd0};
        qu = ua / ub; ru = ua % ub;
        res = {ru[31:0], qu[31:0]};
      end
      default: res = '0;
    endcase
    return {1'b1, res};
  endfunction

  // Model state: committed registers, cycles of Busy left, pending result
  int unsigned rem_cyc = 0;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  logic        p_ok = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem_cyc <= 0;
      m_hi    <= '0;
      m_lo    <= '0;
      p_hi    <= '0;
      p_lo    <= '0;
      p_ok    <= 1'b0;
    end else if (rem_cyc > 0) begin
      rem_cyc <= rem_cyc - 1;
      if (rem_cyc == 1 && p_ok) begin
        m_hi <= p_hi;
        m_lo <= p_lo;
      end
    end else if (start) begin
      if (md_op <= 4'd3) begin
        logic [64:0] r;
        r = compute(md_op, a_in, b_in);
        p_ok    <= r[64];
        p_hi    <= r[63:32];
        p_lo    <= r[31:0];
        rem_cyc <= (md_op <= 4'd1) ? MC : DC;
      end else if (md_op == 4'd6) begin
        m_hi <= a_in;
      end else if (md_op == 4'd7) begin
        m_lo <= a_in;
      end
    end
  end

  always @(negedge clk) begin
    logic [31:0] exp_out;
    exp_out = (md_op == 4'd4) ? m_hi : (md_op == 4'd5) ? m_lo : 32'd0;
    check("cyc_busy", {31'd0, busy}, {31'd0, (rem_cyc > 0)});
    check("cyc_hi", hi, m_hi);
    check("cyc_lo", lo, m_lo);
    check("cyc_mdout", md_out, exp_out);
  end

  task automatic launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #2;
    start = 1'b1; md_op = op; a_in = a; b_in = b;
    @(posedge clk); #2;
    start = 1'b0; md_op = 4'hf;
  endtask

  task automatic wait_idle(output int n);
    bit done;
    n = 0;
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (busy) n++;
      else done = 1;
    end
    if (!done) check("busy_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int n, m;
    reset = 1'b1; start = 1'b0; md_op = 4'h4; a_in = '0; b_in = '0;
    #1 reset = 1'b0;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_mdout", md_out, 32'd0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1; md_op = 4'hf;

    launch(4'd0, 32'hFFFFFFFF, 32'd2);
    wait_idle(n);
    check("mult_busy_len", n, 32'd5);
    check("mult_hi", hi, 32'hFFFFFFFF);
    check("mult_lo", lo, 32'hFFFFFFFE);

    launch(4'd1, 32'hFFFFFFFF, 32'd2);
    wait_idle(n);
    check("multu_hi", hi, 32'h00000001);
    check("multu_lo", lo, 32'hFFFFFFFE);
    md_op = 4'd4; #1;
    check("mfhi_out", md_out, 32'h00000001);

    launch(4'd2, 32'hFFFFFFF9, 32'd2);
    wait_idle(n);
    check("div_busy_len", n, 32'd10);
    check("div_lo", lo, 32'hFFFFFFFD);
    check("div_hi", hi, 32'hFFFFFFFF);

    launch(4'd3, 32'd7, 32'd0);
    wait_idle(n);
    check("divu0_busy_len", n, 32'd10);
    check("divu0_hi", hi, 32'hFFFFFFFF);
    check("divu0_lo", lo, 32'hFFFFFFFD);

    launch(4'd6, 32'h12345678, 32'd0);
    #1 check("mthi_hi", hi, 32'h12345678);

    launch(4'd0, 32'd3, 32'd4);
    @(negedge clk); n = busy ? 1 : 0;
    @(posedge clk); #2 start = 1'b1; md_op = 4'd5;
    @(negedge clk); n += busy ? 1 : 0;
    @(posedge clk); #2 md_op = 4'd6; a_in = 32'hDEADBEEF;
    @(negedge clk); n += busy ? 1 : 0;
    @(posedge clk); #2 start = 1'b0; md_op = 4'hf;
    wait_idle(m);
    check("ignored_busy_len", n + m, 32'd5);
    check("ignored_hi", hi, 32'd0);
    check("ignored_lo", lo, 32'd12);

    launch(4'd2, 32'd100, 32'd7);
    @(negedge clk); @(negedge clk);
    @(posedge clk); #2 reset = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    repeat (15) @(negedge clk);
    check("abort_nocommit_lo", lo, 32'd0);
    check("abort_nocommit_busy", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 600; i++) begin
      logic [31:0] sp[4];
      sp[0] = 32'd0; sp[1] = 32'hFFFFFFFF; sp[2] = 32'h80000000; sp[3] = 32'd1;
      @(posedge clk); #2;
      reset = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
      start = ($urandom_range(0, 2) == 0);
      md_op = 4'($urandom_range(0, 15));
      a_in  = ($urandom_range(0, 3) == 0) ? sp[$urandom_range(0, 3)] : $urandom;
      b_in  = ($urandom_range(0, 3) == 0) ? sp[$urandom_range(0, 3)] : $urandom;
    end
    @(posedge clk); #2 reset = 1'b1; start = 1'b0;
    repeat (12) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Multi-cycle multiply/divide unit in the EX stage, beside the ALU; its `MDOut` is muxed with the ALU result into the EX/MEM register. It executes mult/multu/div/divu against private HI/LO registers and services mfhi/mflo/mthi/mtlo. It raises `Busy` so the hazard unit can stall subsequent MD-class instructions in ID.

## Interface
- `MULT_CYCLES`, default 5: cycles `Busy` stays high for mult/multu.
- `DIV_CYCLES`, default 10: cycles `Busy` stays high for div/divu.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low. Clears all state immediately.
- `A` input 32: rs operand.
- `B` input 32: rt operand.
- `MDOp` input 4: 0 mult, 1 multu, 2 div, 3 divu, 4 mfhi, 5 mflo, 6 mthi, 7 mtlo; 8–15 no-op.
- `Start` input 1: one-cycle launch strobe for `MDOp` 0–3 and 6–7.
- `Busy` output 1: registered; high while an operation is in flight.
- `HI` output 32: committed HI register.
- `LO` output 32: committed LO register.
- `MDOut` output 32: combinational. `HI` when `MDOp`=4, `LO` when `MDOp`=5, else 0.

## Operation
- States: IDLE and RUN, with a down-counter `cnt` (4 bits minimum, sized from the larger parameter).
- IDLE, `Start`=1, `MDOp` 0–3:
  - Sample `A` and `B`.
  - Compute the result into pending registers `pHI`/`pLO`.
  - Load `cnt` with `MULT_CYCLES` or `DIV_CYCLES`.
  - Go to RUN with `Busy`=1.
- Result rules:
  - mult: signed 64-bit product; HI=[63:32], LO=[31:0].
  - multu: unsigned 64-bit product.
  - div: signed, truncating toward zero; LO=quotient, HI=remainder (remainder takes the dividend's sign).
  - divu: unsigned quotient and remainder.
  - `B`=0 for div/divu: the operation still occupies `DIV_CYCLES`, and HI/LO keep their previous values at commit.
- RUN: `cnt` decrements each edge. On the edge where `cnt`=1, copy `pHI`/`pLO` to `HI`/`LO`, clear `Busy`, and return to IDLE.
- IDLE, `Start`=1, `MDOp`=6: `HI`<=`A` at that edge. `MDOp`=7: `LO`<=`A`. `Busy` stays 0.
- `Start` while `Busy`=1: ignored entirely (any op). The hazard unit guarantees this does not happen; the unit must still be safe if it does.
- `Start` with `MDOp` 4, 5, or 8–15: ignored.
- `MDOut` always reflects committed `HI`/`LO`. It never shows pending values.

## Timing
- Reset (async, low) sets `HI`=0, `LO`=0, `Busy`=0, `cnt`=0, `pHI`=0, `pLO`=0, state IDLE. `MDOut`=0 unless `MDOp` is 4 or 5 (then 0 anyway).
- Reset asserted mid-RUN aborts the operation. No commit happens, and everything returns to reset values.
- `Start` sampled at edge k:
  - `Busy` is high in cycles k+1 … k+N (N = `MULT_CYCLES` or `DIV_CYCLES`).
  - New `HI`/`LO` are visible from cycle k+N+1, the same cycle `Busy` first reads 0.
- Back-to-back: a new `Start` is accepted in the first cycle `Busy`=0.
- mthi/mtlo latency: 1 edge. Visible on `HI`/`LO`/`MDOut` the next cycle.
- Parameters must be ≥1. With N=1, `Busy` is high for exactly one cycle.

## Configuration
- `MDU_FLUSH_EN` defined:
  - Adds input `Flush` (1 bit).
  - `Flush`=1 in RUN returns to IDLE at the next edge with no HI/LO commit and `Busy`=0.
  - `Flush`=1 together with `Start` in IDLE suppresses the launch, including mthi/mtlo.
  - `Flush` has priority over `Start` and over the commit edge.
- `MDU_FLUSH_EN` undefined: the port is absent, and operations always run to completion.

## Test plan
- Reset, then mult with `A`=0xFFFFFFFF, `B`=2 → `Busy` high for exactly 5 cycles, then `HI`=0xFFFFFFFF, `LO`=0xFFFFFFFE.
- multu with `A`=0xFFFFFFFF, `B`=2 → `HI`=0x00000001, `LO`=0xFFFFFFFE. `MDOp`=4 gives `MDOut`=0x00000001.
- div with `A`=0xFFFFFFF9 (−7), `B`=2 → after 10 `Busy` cycles, `LO`=0xFFFFFFFD, `HI`=0xFFFFFFFF. Then divu with `A`=7, `B`=0 → `HI`/`LO` unchanged after 10 cycles.
- mthi with `A`=0x12345678, then mflo-style `Start` during a mult's RUN → `HI`=0x12345678 after one edge. The extra `Start` is ignored, and the mult commits on schedule.
- Assert `reset` low at cycle 3 of a div → `Busy`, `HI`, `LO` read 0 immediately, and no commit occurs later.
- With `MDU_FLUSH_EN`: `Flush` at cycle 2 of a mult → `Busy`=0 next cycle and `HI`/`LO` keep their old values.
